controle_relogio: RTL and testbench

Sequencing controller for the digital clock's counter chain. It gates the 1 Hz tick and the inter-counter carries in normal run mode. It also runs a set-time mode: a mode button steps through hour and minute adjustment, and an increment button (with hold auto-repeat) advances the selected counter alone. It sits between the debounced buttons / 1 Hz prescaler and the seconds, minutes and hours counters.

---
 rtl/controle_relogio.sv | 94 +++++++++
 tb/tb_controle_relogio.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/controle_relogio.sv
// controle_relogio: run/set sequencing controller for the digital clock counter chain.
// Optional feature macro: CONTROLE_RELOGIO_BLINK_EN (blink toggle flop built when defined).
// Parameters: HOLD_CYCLES   - clk cycles btn_inc must stay high before auto-repeat starts
//             REPEAT_CYCLES - clk cycles between auto-repeat pulses
//             TIMEOUT_TICKS - tick_1hz pulses without button activity before set mode aborts
// Ports: clk, rst (sync, active-low), tick_1hz, btn_mode, btn_inc, carry_seg, carry_min (in);
//        en_seg, en_min, en_hor, clr_seg, modo[1:0], blink (out).
module controle_relogio #(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 12_500_000,
    parameter int TIMEOUT_TICKS = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       carry_seg,
    input  logic       carry_min,
    output logic       en_seg,
    output logic       en_min,
    output logic       en_hor,
    output logic       clr_seg,
    output logic [1:0] modo,
    output logic       blink
);
    typedef enum logic [1:0] {RUN = 2'b00, SET_HOR = 2'b01, SET_MIN = 2'b10} state_t;

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    state_t        state, next_state;
    logic [HW-1:0] hold_cnt;
    logic [RW-1:0] rep_cnt;
    logic [TW-1:0] timeout_cnt;
    logic          mode_prev, inc_prev, inc_pulse;
    logic          mode_rise, inc_rise, in_set, timed_out, auto_hit, pulse_next;

    always_comb begin
        mode_rise  = btn_mode & ~mode_prev;
        inc_rise   = btn_inc & ~inc_prev;
        in_set     = state != RUN;
        timed_out  = in_set && timeout_cnt == TW'(TIMEOUT_TICKS);
        next_state = mode_rise ? (state == RUN ? SET_HOR : state == SET_HOR ? SET_MIN : RUN)
                   : timed_out ? RUN : state;
        // hold_cnt parks at HOLD_CYCLES once the first repeat has fired; rep_cnt then paces the rest
        auto_hit   = btn_inc && (hold_cnt == HW'(HOLD_CYCLES - 1) ||
                     (hold_cnt == HW'(HOLD_CYCLES) && rep_cnt == RW'(REPEAT_CYCLES - 1)));
        // an increment coinciding with any state change is dropped
        pulse_next = in_set && next_state == state && (inc_rise || auto_hit);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= RUN;
            mode_prev   <= 1'b1;
            inc_prev    <= 1'b1;
            inc_pulse   <= 1'b0;
            clr_seg     <= 1'b0;
            hold_cnt    <= '0;
            rep_cnt     <= '0;
            timeout_cnt <= '0;
        end else begin
            state       <= next_state;
            mode_prev   <= btn_mode;
            inc_prev    <= btn_inc;
            inc_pulse   <= pulse_next;
            clr_seg     <= in_set && next_state == RUN;
            hold_cnt    <= !btn_inc ? '0 : hold_cnt == HW'(HOLD_CYCLES) ? hold_cnt : hold_cnt + 1'b1;
            rep_cnt     <= (!btn_inc || hold_cnt != HW'(HOLD_CYCLES) || rep_cnt == RW'(REPEAT_CYCLES - 1))
                           ? '0 : rep_cnt + 1'b1;
            timeout_cnt <= (next_state == RUN || next_state != state || inc_pulse) ? '0
                         : timeout_cnt + TW'(tick_1hz);
        end
    end

`ifdef CONTROLE_RELOGIO_BLINK_EN
    // cleared together with the increment pulse so the field is visible while it changes
    always_ff @(posedge clk) begin
        if (!rst)
            blink <= 1'b0;
        else
            blink <= (next_state == RUN || next_state != state || pulse_next) ? 1'b0 : blink ^ tick_1hz;
    end
`else
    assign blink = 1'b0;
`endif

    assign modo   = state;
    assign en_seg = tick_1hz & (state == RUN);
    assign en_min = state == RUN ? carry_seg : (state == SET_MIN) & inc_pulse;
    assign en_hor = state == RUN ? carry_min : (state == SET_HOR) & inc_pulse;
endmodule

// File: tb/tb_controle_relogio.sv
// tb_controle_relogio: scoreboard bench for controle_relogio with short hold/repeat/timeout.
module tb_controle_relogio;
`ifdef CONTROLE_RELOGIO_BLINK_EN
    localparam bit BL = 1'b1;
`else
    localparam bit BL = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [1:0] m;
        logic       s, mi, h, c, b;
    } ev_t;

    logic clk = 1'b0, rst = 1'b0;
    logic tick_1hz = 0, btn_mode = 0, btn_inc = 0, carry_seg = 0, carry_min = 0;
    logic en_seg, en_min, en_hor, clr_seg, blink;
    logic [1:0] modo;

    int   cyc = 0, errors = 0, checks = 0;
    bit   mon_on = 0;
    logic [1:0] last_m = 2'b00;
    logic last_b = 1'b0;
    ev_t  q[$];

    controle_relogio #(.HOLD_CYCLES(8), .REPEAT_CYCLES(4), .TIMEOUT_TICKS(3)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .carry_seg(carry_seg), .carry_min(carry_min), .en_seg(en_seg), .en_min(en_min),
        .en_hor(en_hor), .clr_seg(clr_seg), .modo(modo), .blink(blink)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: every visible output event must match the head of the expectation queue
    always @(negedge clk) begin
        if (mon_on) begin
            if (en_seg | en_min | en_hor | clr_seg | (modo != last_m) | (blink != last_b)) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d got modo=%b seg=%b min=%b hor=%b clr=%b blink=%b, expected no event",
                             cyc, modo, en_seg, en_min, en_hor, clr_seg, blink);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    if (e.cyc != cyc || {e.m, e.s, e.mi, e.h, e.c, e.b} !== {modo, en_seg, en_min, en_hor, clr_seg, blink}) begin
                        errors++;
                        $display("FAIL event cyc=%0d got modo=%b seg=%b min=%b hor=%b clr=%b blink=%b, expected cyc=%0d modo=%b seg=%b min=%b hor=%b clr=%b blink=%b",
                                 cyc, modo, en_seg, en_min, en_hor, clr_seg, blink,
                                 e.cyc, e.m, e.s, e.mi, e.h, e.c, e.b);
                    end
                end
            end
            last_m = modo;
            last_b = blink;
        end
    end

    task automatic nxt(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int dc, input logic [1:0] m, input logic s, mi, h, c, b);
        q.push_back('{cyc + dc, m, s, mi, h, c, b});
    endtask

    task automatic pb(input int dc, input logic [1:0] m, input logic b);
        if (BL) push(dc, m, 0, 0, 0, 0, b);
    endtask

    task automatic press_mode(input logic [1:0] m, input logic c);
        push(1, m, 0, 0, 0, c, 0);
        btn_mode = 1;
        nxt();
        btn_mode = 0;
        nxt();
    endtask

    task automatic tick_once();
        tick_1hz = 1;
        nxt();
        tick_1hz = 0;
        nxt();
    endtask

    task automatic inc_once(input logic [1:0] m);
        push(1, m, 0, m == 2'b10, m == 2'b01, 0, 0);
        btn_inc = 1;
        nxt();
        btn_inc = 0;
        nxt();
    endtask

    initial begin
        nxt(3);
        rst = 1;
        nxt();
        checks++;
        if ({modo, en_seg, en_min, en_hor, clr_seg, blink} !== 7'b0) begin
            errors++;
            $display("FAIL reset_state got modo=%b seg=%b min=%b hor=%b clr=%b blink=%b, expected all 0",
                     modo, en_seg, en_min, en_hor, clr_seg, blink);
        end
        mon_on = 1;
        // RUN: seconds tick and carries pass straight through
        for (int i = 0; i < 3; i++) begin
            tick_1hz = 1;
            push(0, 0, 1, 0, 0, 0, 0);
            tick_once();
        end
        carry_seg = 1;
        push(0, 0, 0, 1, 0, 0, 0);
        nxt();
        carry_seg = 0;
        carry_min = 1;
        push(0, 0, 0, 0, 1, 0, 0);
        nxt();
        tick_1hz = 1;
        carry_seg = 1;
        push(0, 0, 1, 1, 1, 0, 0);
        nxt();
        {tick_1hz, carry_seg, carry_min} = 3'b000;
        nxt();
        // SET_HOR: carries ignored
        press_mode(2'b01, 0);
        carry_seg = 1;
        carry_min = 1;
        nxt(2);
        carry_seg = 0;
        carry_min = 0;
        nxt();
        // SET_MIN: one increment with a stray minutes carry
        press_mode(2'b10, 0);
        push(1, 2, 0, 1, 0, 0, 0);
        btn_inc = 1;
        carry_min = 1;
        nxt(2);
        btn_inc = 0;
        carry_min = 0;
        nxt(2);
        press_mode(2'b00, 1);
        // SET_HOR hold auto-repeat
        press_mode(2'b01, 0);
        push(1, 1, 0, 0, 1, 0, 0);
        push(8, 1, 0, 0, 1, 0, 0);
        push(12, 1, 0, 0, 1, 0, 0);
        push(16, 1, 0, 0, 1, 0, 0);
        push(20, 1, 0, 0, 1, 0, 0);
        btn_inc = 1;
        nxt(20);
        btn_inc = 0;
        nxt(3);
        // timeout after three ticks
        for (int i = 0; i < 3; i++) begin
            tick_1hz = 1;
            pb(1, 1, i % 2 == 0);
            if (i == 2) push(2, 0, 0, 0, 0, 1, 0);
            tick_once();
        end
        nxt(2);
        // mode and inc together: state advances, increment dropped
        press_mode(2'b01, 0);
        push(1, 2, 0, 0, 0, 0, 0);
        btn_mode = 1;
        btn_inc = 1;
        nxt(2);
        btn_mode = 0;
        btn_inc = 0;
        nxt(2);
        press_mode(2'b00, 1);
        // blink behaviour in SET_MIN
        press_mode(2'b01, 0);
        press_mode(2'b10, 0);
        pb(1, 2, 1); tick_once();
        pb(1, 2, 0); tick_once();
        inc_once(2'b10);
        pb(1, 2, 1); tick_once();
        pb(1, 2, 0); tick_once();
        inc_once(2'b10);
        pb(1, 2, 1); tick_once();
        inc_once(2'b10);
        pb(1, 2, 1); tick_once();
        // reset mid-set
        rst = 0;
        push(1, 0, 0, 0, 0, 0, 0);
        nxt(2);
        rst = 1;
        nxt(2);
        press_mode(2'b01, 0);
        // mode button held through reset gives no edge
        rst = 0;
        btn_mode = 1;
        push(1, 0, 0, 0, 0, 0, 0);
        nxt(2);
        rst = 1;
        nxt(3);
        btn_mode = 0;
        nxt(5);
        mon_on = 0;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_events got %0d still pending (next expected at cyc=%0d), expected 0",
                     q.size(), q[0].cyc);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
